// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: writer end of the connection-block configuration chain.
// Accepts WORD_W-bit words over a valid/ready handshake and shifts them MSB
// first onto ccff_head, raising config_enable only on cycles that carry a real
// bit. Completion is reported after exactly CHAIN_LEN shifts; a partial last
// word keeps only its top bits.
// Optional feature: define CCFF_TAIL_CRC_EN to add tail_crc, a CRC-8
// (poly 0x07, init 0x00) of the old chain contents pushed out on ccff_tail.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 36,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pResetn,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_shifted
`ifdef CCFF_TAIL_CRC_EN
  ,
  output logic [7:0]        tail_crc
`endif
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic [IDX_W-1:0]  bit_idx, bit_idx_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              head_q, head_n;
  logic              en_q, en_n;

  // Next-state and datapath decode; head/enable are precomputed so they leave registers directly.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    cnt_n      = cnt_q;
    busy_n     = busy_q;
    done_n     = done_q;
    word_ready = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_FETCH;
          cnt_n   = '0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end

      ST_FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          shreg_n   = word_in;
          bit_idx_n = IDX_TOP;
          state_n   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != FULL_CNT) begin
          cnt_n = cnt_q + ONE_CNT;
        end
        if (cnt_q >= LAST_CNT) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (bit_idx == '0) begin
          state_n = ST_FETCH;
        end else begin
          bit_idx_n = bit_idx - 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    en_n   = (state_n == ST_SHIFT);
    head_n = en_n & shreg_n[bit_idx_n];
  end

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge prog_clk or negedge pResetn) begin
    if (!pResetn) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      cnt_q   <= cnt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      head_q  <= head_n;
      en_q    <= en_n;
    end
  end

  assign ccff_head     = head_q;
  assign config_enable = en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bits_shifted  = cnt_q;

`ifdef CCFF_TAIL_CRC_EN
  logic [7:0] crc_q;
  logic       crc_fb;

  assign crc_fb = crc_q[7] ^ ccff_tail;

  // CRC-8 over bits leaving the chain tail on every shifting cycle; cleared when a load starts.
  always_ff @(posedge prog_clk or negedge pResetn) begin
    if (!pResetn) begin
      crc_q <= 8'h00;
    end else if (start && (state == ST_IDLE || state == ST_DONE)) begin
      crc_q <= 8'h00;
    end else if (en_q) begin
      crc_q <= {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end
  end

  assign tail_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: drives loads into ccff_chain_loader, models the
// configuration chain, and scoreboards every shifted bit against the words
// handed over. Define CCFF_TAIL_CRC_EN to also check tail_crc.
module tb_ccff_chain_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 36;
  localparam int CNT_W     = 16;
  localparam int NWORDS    = 5;
  localparam int MAX_CYC   = 400;

  logic              prog_clk = 1'b0;
  logic              pResetn = 1'b0;
  logic              start = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic              ccff_head;
  logic              config_enable;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  bits_shifted;
`ifdef CCFF_TAIL_CRC_EN
  logic [7:0]        tail_crc;
`endif

  logic [CHAIN_LEN-1:0] chain;
  logic                 preload_req = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   en_count = 0;
  int   hs_count = 0;
  bit   exp_q[$];
  logic [WORD_W-1:0] words [NWORDS];

  typedef struct {
    string                name;
    int                   stall_word;
    int                   stall_cyc;
    bit                   mid_start;
    bit                   junk;
    int                   exp_bits;
    int                   exp_en;
    int                   exp_hs;
    logic [CHAIN_LEN-1:0] exp_chain;
  } scenario_t;

  ccff_chain_loader #(
    .WORD_W(WORD_W),
    .CHAIN_LEN(CHAIN_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .prog_clk(prog_clk),
    .pResetn(pResetn),
    .start(start),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .ccff_head(ccff_head),
    .config_enable(config_enable),
    .ccff_tail(ccff_tail),
    .busy(busy),
    .done(done),
    .bits_shifted(bits_shifted)
`ifdef CCFF_TAIL_CRC_EN
    ,
    .tail_crc(tail_crc)
`endif
  );

  // Free-running programming clock.
  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: shifts in ccff_head whenever enabled, or takes an all-ones preload.
  always @(posedge prog_clk) begin
    if (preload_req) chain <= '1;
    else if (config_enable) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end

  assign ccff_tail = chain[CHAIN_LEN-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: each enabled cycle must carry the next expected bit; idle cycles hold head low.
  always @(negedge prog_clk) begin
    if (pResetn) begin
      if (config_enable) begin
        en_count++;
        if (exp_q.size() == 0) checkOutput("extra_shift", 1, 0);
        else checkOutput("head_bit", ccff_head, exp_q.pop_front());
        checkOutput("busy_in_shift", busy, 1);
      end else begin
        checkOutput("head_idle_zero", ccff_head, 0);
      end
    end
  end

  function automatic logic [7:0] crc8_ones(input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = c[7] ^ 1'b1;
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ready"}, word_ready, 0);
    checkOutput({tag, "_head"}, ccff_head, 0);
    checkOutput({tag, "_enable"}, config_enable, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_bits"}, bits_shifted, 0);
`ifdef CCFF_TAIL_CRC_EN
    checkOutput({tag, "_crc"}, tail_crc, 0);
`endif
  endtask

  // One load: start pulse, then feed words as the DUT asks, with optional stall, junk and extra start.
  task automatic applyStimulus(input scenario_t sc, input int abort_after, output bit aborted);
    int widx, stall_left, pushed, cyc;
    bit pulsed;
    widx = 0; stall_left = sc.stall_cyc; pushed = 0; cyc = 0; pulsed = 0; aborted = 0;
    en_count = 0; hs_count = 0; exp_q.delete();
    @(negedge prog_clk); #1; start = 1'b1;
    @(negedge prog_clk); #1; start = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      if (abort_after > 0 && en_count >= abort_after) begin
        aborted = 1;
        break;
      end
      start = 1'b0; word_valid = 1'b0; word_in = '0;
      if (word_ready) begin
        if (widx == sc.stall_word && stall_left > 0) begin
          stall_left--;
          checkOutput("stall_enable_low", config_enable, 0);
          checkOutput("stall_busy", busy, 1);
        end else if (widx < NWORDS) begin
          word_valid = 1'b1;
          word_in = words[widx];
          for (int b = WORD_W - 1; b >= 0; b--) begin
            if (pushed < CHAIN_LEN) begin
              exp_q.push_back(words[widx][b]);
              pushed++;
            end
          end
          widx++;
          hs_count++;
        end
      end else if (sc.junk) begin
        word_valid = 1'b1;
        word_in = 8'hEE;
      end
      if (sc.mid_start && !pulsed && widx == 2 && config_enable) begin
        start = 1'b1;
        pulsed = 1;
      end
      @(negedge prog_clk); #1; cyc++;
    end
    start = 1'b0; word_valid = 1'b0; word_in = '0;
    if (abort_after == 0) checkOutput({sc.name, "_timeout"}, (cyc >= MAX_CYC), 0);
  endtask

  task automatic checkLoad(input scenario_t sc);
    checkOutput({sc.name, "_done"}, done, 1);
    checkOutput({sc.name, "_busy"}, busy, 0);
    checkOutput({sc.name, "_bits"}, bits_shifted, sc.exp_bits);
    checkOutput({sc.name, "_enable_cycles"}, en_count, sc.exp_en);
    checkOutput({sc.name, "_handshakes"}, hs_count, sc.exp_hs);
    checkOutput({sc.name, "_leftover"}, exp_q.size(), 0);
    checkOutput({sc.name, "_chain"}, chain, sc.exp_chain);
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, table of loads, mid-load reset, restart from DONE, optional CRC.
  initial begin
    scenario_t tbl[3];
    bit        aborted;
    logic [7:0] crc_ref;

    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h9F};
    tbl[0] = '{"full",  -1, 0, 1'b0, 1'b0, 36, 36, 5, 36'hA53CFF009};
    tbl[1] = '{"stall",  2, 4, 1'b0, 1'b0, 36, 36, 5, 36'hA53CFF009};
    tbl[2] = '{"restart_ignored", -1, 0, 1'b1, 1'b1, 36, 36, 5, 36'hA53CFF009};

    pResetn = 1'b0;
    repeat (3) @(negedge prog_clk);
    #1;
    checkQuiet("in_reset");
    pResetn = 1'b1;
    repeat (2) @(negedge prog_clk);
    #1;
    checkQuiet("idle");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(tbl[i], 0, aborted);
      checkLoad(tbl[i]);
      repeat (3) @(negedge prog_clk);
      #1;
      checkOutput({tbl[i].name, "_bits_hold"}, bits_shifted, 36);
      checkOutput({tbl[i].name, "_done_hold"}, done, 1);
    end

    applyStimulus(tbl[0], 13, aborted);
    checkOutput("abort_reached", aborted, 1);
    checkOutput("abort_enable_high", config_enable, 1);
    pResetn = 1'b0;
    #1;
    checkQuiet("async_reset");
    exp_q.delete();
    repeat (2) @(negedge prog_clk);
    #1;
    pResetn = 1'b1;
    applyStimulus(tbl[0], 0, aborted);
    checkLoad(tbl[0]);

`ifdef CCFF_TAIL_CRC_EN
    preload_req = 1'b1;
    @(posedge prog_clk);
    #1;
    preload_req = 1'b0;
    checkOutput("preload_chain", chain, 36'hFFFFFFFFF);
    crc_ref = crc8_ones(CHAIN_LEN);
    applyStimulus(tbl[0], 0, aborted);
    checkLoad(tbl[0]);
    checkOutput("crc_after_load", tail_crc, crc_ref);
    repeat (3) @(negedge prog_clk);
    #1;
    checkOutput("crc_stable_done", tail_crc, crc_ref);
`else
    crc_ref = 8'h00;
`endif

    @(negedge prog_clk); #1; start = 1'b1;
    @(negedge prog_clk); #1; start = 1'b0;
    checkOutput("restart_done_cleared", done, 0);
    checkOutput("restart_bits_cleared", bits_shifted, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_ready", word_ready, 1);
`ifdef CCFF_TAIL_CRC_EN
    checkOutput("crc_cleared_on_start", tail_crc, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
